// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: multi-channel button conditioner on full_clock.
// A shared prescaler produces a one-cycle sample tick. Each channel has a
// two-flop synchronizer, a stable-count debouncer, registered press/release
// pulses and an optional auto-repeat FSM (OFF -> DELAY -> RATE).
module btn_debounce_bank #(
    parameter int N_CH         = 5,
    parameter int TICK_DIV     = 4096,
    parameter int STABLE_TICKS = 16,
    parameter int REPEAT_DELAY = 12207,
    parameter int REPEAT_RATE  = 2441
) (
    input  logic            full_clock,
    input  logic            Reset,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse,
    output logic [N_CH-1:0] btn_release,
    output logic            tick
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(STABLE_TICKS) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [PW-1:0] PCNT_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_OFF   = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_e;

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            tick_q, tick_d;
    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] btn_level_q, btn_level_d;
    logic [N_CH-1:0] btn_pulse_q, btn_pulse_d;
    logic [N_CH-1:0] btn_release_q, btn_release_d;
    logic [DW-1:0]   dcnt_q [N_CH];
    logic [DW-1:0]   dcnt_d [N_CH];
    logic [RW-1:0]   rcnt_q [N_CH];
    logic [RW-1:0]   rcnt_d [N_CH];
    rpt_state_e      state_q [N_CH];
    rpt_state_e      state_d [N_CH];

    assign btn_level   = btn_level_q;
    assign btn_pulse   = btn_pulse_q;
    assign btn_release = btn_release_q;
    assign tick        = tick_q;

    // Prescaler: wrap at TICK_DIV-1 and strobe tick in the following cycle.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PW'(1);
        tick_d = (pcnt_q == PCNT_LAST);
    end

    // Synchronizer: raw inputs pass through two flops before any use.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Per-channel debounce and repeat next-state, evaluated only in tick cycles.
    always_comb begin
        btn_level_d   = btn_level_q;
        btn_pulse_d   = '0;
        btn_release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            dcnt_d[i]  = dcnt_q[i];
            rcnt_d[i]  = rcnt_q[i];
            state_d[i] = state_q[i];
            if (tick_q) begin
                // Debounce: a run of differing samples flips the level; any agreeing sample restarts it.
                if (sync2_q[i] != btn_level_q[i]) begin
                    if (dcnt_q[i] == DCNT_LAST) begin
                        btn_level_d[i]   = sync2_q[i];
                        dcnt_d[i]        = '0;
                        btn_pulse_d[i]   = sync2_q[i];
                        btn_release_d[i] = ~sync2_q[i];
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end else begin
                    dcnt_d[i] = '0;
                end
                // Repeat: judged on the post-tick level, so a press tick arms DELAY
                // and a release tick forces OFF without a repeat pulse.
                if (!btn_level_d[i] || !repeat_en[i]) begin
                    state_d[i] = RPT_OFF;
                    rcnt_d[i]  = '0;
                end else begin
                    case (state_q[i])
                        RPT_OFF: begin
                            state_d[i] = RPT_DELAY;
                            rcnt_d[i]  = '0;
                        end
                        RPT_DELAY: begin
                            if (rcnt_q[i] == DELAY_LAST) begin
                                btn_pulse_d[i] = 1'b1;
                                rcnt_d[i]      = '0;
                                state_d[i]     = RPT_RATE;
                            end else begin
                                rcnt_d[i] = rcnt_q[i] + RW'(1);
                            end
                        end
                        RPT_RATE: begin
                            if (rcnt_q[i] == RATE_LAST) begin
                                btn_pulse_d[i] = 1'b1;
                                rcnt_d[i]      = '0;
                            end else begin
                                rcnt_d[i] = rcnt_q[i] + RW'(1);
                            end
                        end
                        default: begin
                            state_d[i] = RPT_OFF;
                            rcnt_d[i]  = '0;
                        end
                    endcase
                end
            end
        end
    end

    // Prescaler, synchronizer, debounce counters and output registers.
    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            pcnt_q        <= '0;
            tick_q        <= 1'b0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            btn_level_q   <= '0;
            btn_pulse_q   <= '0;
            btn_release_q <= '0;
            // NOTE: the per-channel counter arrays are plain registers, not a memory, so they reset with everything else.
            for (int i = 0; i < N_CH; i++) begin
                dcnt_q[i] <= '0;
                rcnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            pcnt_q        <= pcnt_d;
            tick_q        <= tick_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_level_q   <= btn_level_d;
            btn_pulse_q   <= btn_pulse_d;
            btn_release_q <= btn_release_d;
            for (int i = 0; i < N_CH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    // Repeat FSM state register.
    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= RPT_OFF;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

endmodule
